// File: rtl/layer_engine_activator_sched_pkg.sv
// Shared definitions for the activator scheduler: one-hot FSM encoding and width helper.
package layer_engine_activator_sched_pkg;

    // Bit 3 is reserved for a future state.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_ISSUE = 4'b0010,
        ST_RUN   = 4'b0100
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/layer_engine_activator_sched_arb.sv
// Combinational round-robin arbiter: lowest requester index at or above ptr wins, else wraps.
module layer_engine_activator_sched_arb
    import layer_engine_activator_sched_pkg::*;
#(
    parameter int C_NUM_REQ = 4,
    parameter int IW        = clog2(C_NUM_REQ)
) (
    input  logic [C_NUM_REQ-1:0] req,
    input  logic [IW-1:0]        ptr,
    output logic [C_NUM_REQ-1:0] grant_oh,
    output logic [IW-1:0]        grant_idx,
    output logic                 any_req
);

    logic found;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
        for (int i = 0; i < C_NUM_REQ; i++) begin
            if (!found && req[i] && (IW'(i) >= ptr)) begin
                found       = 1'b1;
                grant_oh[i] = 1'b1;
                grant_idx   = IW'(i);
            end
        end
        for (int i = 0; i < C_NUM_REQ; i++) begin
            if (!found && req[i] && (IW'(i) < ptr)) begin
                found       = 1'b1;
                grant_oh[i] = 1'b1;
                grant_idx   = IW'(i);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/layer_engine_activator_sched.sv
// Round-robin scheduler sharing one activation engine among C_NUM_REQ layer engines.
module layer_engine_activator_sched
    import layer_engine_activator_sched_pkg::*;
#(
    parameter int          C_NUM_REQ        = 4,
    parameter int          C_OPCODE_WIDTH   = 64,
    parameter int unsigned C_TIMEOUT_CYCLES = 65535
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [C_NUM_REQ*C_OPCODE_WIDTH-1:0] req_opcode,
    input  logic [C_NUM_REQ-1:0]                req_valid,
    output logic [C_NUM_REQ-1:0]                req_accept,
    output logic [C_NUM_REQ-1:0]                req_complete,
    output logic [C_OPCODE_WIDTH-1:0]           act_opcode,
    output logic                                act_opcode_valid,
    input  logic                                act_opcode_accept,
    input  logic                                act_opcode_complete,
    output logic [clog2(C_NUM_REQ)-1:0]         grant_id,
    output logic                                grant_valid,
    output logic                                busy,
    output logic                                timeout_err
);

    localparam int IW = clog2(C_NUM_REQ);

    state_t                    state, state_n;
    logic [IW-1:0]             rr_ptr;
    logic [IW-1:0]             arb_idx;
    logic [C_NUM_REQ-1:0]      arb_oh;
    logic                      any_req;
    logic                      load, take, done;
    logic [C_OPCODE_WIDTH-1:0] opc_sel;
    logic [31:0]               wd_cnt;
    logic [C_NUM_REQ-1:0]      owner_oh;
    logic [IW-1:0]             ptr_next;

    layer_engine_activator_sched_arb #(
        .C_NUM_REQ (C_NUM_REQ),
        .IW        (IW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant_oh  (arb_oh),
        .grant_idx (arb_idx),
        .any_req   (any_req)
    );

    always_comb begin
        opc_sel = '0;
        for (int i = 0; i < C_NUM_REQ; i++) begin
            if (arb_oh[i]) opc_sel = req_opcode[i*C_OPCODE_WIDTH +: C_OPCODE_WIDTH];
        end
    end

    assign owner_oh = {{(C_NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
    assign ptr_next = (grant_id == IW'(C_NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_n;
    end

    // Complete without a prior or simultaneous accept is not meaningful and is ignored.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        take    = 1'b0;
        done    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (any_req) begin
                    load    = 1'b1;
                    state_n = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (act_opcode_accept) begin
                    take = 1'b1;
                    if (act_opcode_complete) begin
                        done    = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (act_opcode_complete) begin
                    done    = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_opcode   <= '0;
            grant_id     <= '0;
            rr_ptr       <= '0;
            req_accept   <= '0;
            req_complete <= '0;
            wd_cnt       <= '0;
            timeout_err  <= 1'b0;
        end else begin
            req_accept   <= take ? owner_oh : '0;
            req_complete <= done ? owner_oh : '0;
            if (load) begin
                act_opcode <= opc_sel;
                grant_id   <= arb_idx;
            end
            if (done) rr_ptr <= ptr_next;
            // Watchdog saturates rather than wrapping so a stuck job cannot re-arm it.
            if (load)                                      wd_cnt <= '0;
            else if (state != ST_IDLE && wd_cnt != '1)     wd_cnt <= wd_cnt + 32'd1;
            if (C_TIMEOUT_CYCLES != 0 && state != ST_IDLE && wd_cnt == 32'(C_TIMEOUT_CYCLES))
                timeout_err <= 1'b1;
        end
    end

    assign act_opcode_valid = (state == ST_ISSUE);
    assign grant_valid      = (state == ST_ISSUE) || (state == ST_RUN);
    assign busy             = (state != ST_IDLE);

endmodule
